// File: rtl/mc_rdata_pack.sv
// Gathers RATIO array read words into one AXI R beat per group; rvalid/rlast are registered one cycle after the closing word.
// Optional: define MC_RPACK_DROP_CNT_EN to add the saturating rpack_drop_cnt output.
`timescale 1ns/1ps
module mc_rdata_pack #(
  parameter int AXI_DATA_WIDTH   = 256,
  parameter int ARRAY_DATA_WIDTH = 64,
  parameter int AXI_LEN_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mc_en,
  input  logic                        rd_cmd_vld,
  output logic                        rd_cmd_rdy,
  input  logic [AXI_LEN_WIDTH-1:0]    rd_cmd_len,
  input  logic                        array_rdata_vld,
  input  logic [ARRAY_DATA_WIDTH-1:0] array_rdata,
  output logic                        axi_s_rvalid,
  output logic                        axi_s_rlast,
  output logic [AXI_DATA_WIDTH-1:0]   axi_s_rdata,
  output logic                        rpack_busy,
  output logic                        rpack_drop
`ifdef MC_RPACK_DROP_CNT_EN
  ,
  output logic [7:0]                  rpack_drop_cnt
`endif
);

  localparam int RATIO = AXI_DATA_WIDTH / ARRAY_DATA_WIDTH;
  localparam int WCW   = $clog2(RATIO);

  typedef enum logic {IDLE, PACK} state_t;

  state_t                    state, state_nxt;
  logic [WCW-1:0]            word_cnt;
  logic [AXI_LEN_WIDTH-1:0]  beat_cnt, len_q;
  logic [AXI_DATA_WIDTH-1:0] pack_q, pack_nxt;
  logic                      cmd_acc, word_acc, beat_done, last_beat, drop_now;

  always_comb begin
    state_nxt  = state;
    rd_cmd_rdy = 1'b0;
    rpack_busy = 1'b0;
    cmd_acc    = 1'b0;
    word_acc   = 1'b0;
    beat_done  = 1'b0;
    drop_now   = 1'b0;
    last_beat  = (beat_cnt == len_q);
    case (state)
      IDLE: begin
        rd_cmd_rdy = mc_en;
        cmd_acc    = rd_cmd_vld & mc_en;
        drop_now   = array_rdata_vld;
        if (cmd_acc) state_nxt = PACK;
      end
      PACK: begin
        rpack_busy = 1'b1;
        word_acc   = array_rdata_vld;
        beat_done  = array_rdata_vld && (word_cnt == WCW'(RATIO - 1));
        if (beat_done && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Merged beat including the word arriving this cycle; feeds both pack and output registers.
  always_comb begin
    pack_nxt = pack_q;
    pack_nxt[word_cnt*ARRAY_DATA_WIDTH +: ARRAY_DATA_WIDTH] = array_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_cnt     <= '0;
      beat_cnt     <= '0;
      len_q        <= '0;
      pack_q       <= '0;
      axi_s_rdata  <= '0;
      axi_s_rvalid <= 1'b0;
      axi_s_rlast  <= 1'b0;
      rpack_drop   <= 1'b0;
    end else begin
      state        <= state_nxt;
      axi_s_rvalid <= beat_done;
      axi_s_rlast  <= beat_done & last_beat;
      rpack_drop   <= drop_now;
      if (cmd_acc) begin
        len_q    <= rd_cmd_len;
        beat_cnt <= '0;
        word_cnt <= '0;
      end
      if (word_acc) begin
        pack_q   <= pack_nxt;
        word_cnt <= word_cnt + 1'b1;
      end
      if (beat_done) begin
        axi_s_rdata <= pack_nxt;
        beat_cnt    <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef MC_RPACK_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rpack_drop_cnt <= '0;
    else if (drop_now && rpack_drop_cnt != 8'hFF)
      rpack_drop_cnt <= rpack_drop_cnt + 8'd1;
  end
`endif

endmodule
